// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//
// Data-memory responder for the MEM stage. Each 32-bit load or store is
// carried out as two 16-bit accesses on an external asynchronous SRAM: low
// halfword first, then high halfword. Each half takes ACCESS_CYCLES cycles.
// After both halves there is a single DONE cycle in which the load result
// is valid. `ready` is low while an access is in flight, so the pipeline
// freezes for that time.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   asynchronous reset, active low
//   rd_en       in   load request
//   wr_en       in   store request (wins when both are high)
//   address     in   32-bit CPU byte address
//   write_data  in   32-bit store data
//   read_data   out  registered load result, holds until the next load ends
//   ready       out  high when idle without a request, or in DONE
//   SRAM_DQ     io   16-bit SRAM data bus (driven only during writes)
//   SRAM_ADDR   out  18-bit SRAM halfword address
//   SRAM_WE_N   out  SRAM write enable, active low
//   SRAM_OE_N   out  SRAM output enable, active low
// ---------------------------------------------------------------------------
module sram_controller #(
   parameter logic [31:0] BASE_ADDR     = 32'd1024,
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N
);

   localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [16:0]       addr_q, addr_d;      // word index latched at request
   logic [31:0]       wdata_q, wdata_d;
   logic              is_wr_q, is_wr_d;
   logic [15:0]       lo_half_q, lo_half_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [31:0]       eff;
   logic              req;
   logic              cnt_last;
   logic              dq_oe;
   logic [15:0]       dq_out;
   logic              unused_eff;

   // Byte offset from the SRAM base. The subtraction wraps, and only the
   // word index is kept, so out-of-range addresses alias onto the SRAM.
   assign eff        = address - BASE_ADDR;
   assign unused_eff = ^{eff[31:19], eff[1:0]};

   assign req       = rd_en | wr_en;
   assign cnt_last  = (cnt_q == CNT_LAST);
   assign ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
   assign read_data = rdata_q;

   // The data bus is released whenever we are not in a write half.
   assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         is_wr_q   <= 1'b0;
         lo_half_q <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         is_wr_q   <= is_wr_d;
         lo_half_q <= lo_half_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      is_wr_d   = is_wr_q;
      lo_half_d = lo_half_q;
      rdata_d   = rdata_q;

      SRAM_ADDR = '0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      dq_oe     = 1'b0;
      dq_out    = '0;

      // Pin drive is identical in both halves apart from the halfword select.
      if (state_q == LO || state_q == HI) begin
         SRAM_ADDR = {addr_q, (state_q == HI)};
         SRAM_WE_N = !is_wr_q;
         SRAM_OE_N = is_wr_q;
         dq_oe     = is_wr_q;
         dq_out    = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
      end

      unique case (state_q)
         IDLE: begin
            if (req) begin
               addr_d  = eff[18:2];
               wdata_d = write_data;
               is_wr_d = wr_en;
               cnt_d   = '0;
               state_d = LO;
            end
         end
         LO: begin
            if (cnt_last) begin
               // Sample the low half at the end of its window so the SRAM
               // has had the full access time to settle.
               if (!is_wr_q) lo_half_d = SRAM_DQ;
               cnt_d   = '0;
               state_d = HI;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HI: begin
            if (cnt_last) begin
               if (!is_wr_q) rdata_d = {SRAM_DQ, lo_half_q};
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
//
// Bench for sram_controller. An asynchronous SRAM model sits on the pins;
// a word-level reference memory predicts load results, bus contents and the
// SRAM image. Table-driven transactions, directed corner sequences
// (reset, back-to-back loads, abort) and random transactions are checked.
// ---------------------------------------------------------------------------
module tb_sram_controller;

   localparam int          AC   = 2;
   localparam logic [31:0] BASE = 32'd1024;
   localparam int          P    = 2 + 2 * AC;   // cycles per request incl. DONE

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0, wr_en = 1'b0;
   logic [31:0] address = '0, write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        we_n, oe_n;

   int n_cmp = 0;
   int n_bad = 0;

   sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rst(rst_n), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .write_data(write_data),
      .read_data(read_data), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
      .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM: drives the bus when read-enabled, stores on edges
   // while write-enabled.
   bit [15:0] sram [262144];
   assign sram_dq = (!oe_n && we_n) ? sram[sram_addr] : 16'hzzzz;
   always @(posedge clk) if (!we_n) sram[sram_addr] <= sram_dq;

   // Word-level reference memory.
   bit [31:0] ref_mem [bit [16:0]];
   logic [31:0] cur_rd = '0;

   function automatic logic [31:0] ref_rd(input bit [16:0] w);
      return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
   endfunction

   task automatic poke(input bit [16:0] w, input logic [31:0] v);
      sram[{w, 1'b0}] = v[15:0];
      sram[{w, 1'b1}] = v[31:16];
      ref_mem[w] = v;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One full request, starting from IDLE. The request is withdrawn and the
   // address scrambled after the first edge; the latched access must finish.
   task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
      logic [31:0] eff;
      bit [16:0]   w;
      logic [31:0] old;
      bit          hi;
      eff = addr - BASE;
      w   = eff[18:2];
      old = ref_rd(w);
      @(posedge clk); #1;
      rd_en = rd; wr_en = wr; address = addr; write_data = wd;
      @(negedge clk);
      chk("ready_req", {31'b0, ready}, 32'd0);
      for (int k = 1; k <= 2 * AC + 1; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
         end
         @(negedge clk);
         if (k <= 2 * AC) begin
            hi = (k > AC);
            chk("ready_busy", {31'b0, ready}, 32'd0);
            chk("sram_addr", {14'b0, sram_addr}, {14'b0, w, hi});
            chk("we_n", {31'b0, we_n}, {31'b0, !wr});
            chk("oe_n", {31'b0, oe_n}, {31'b0, wr});
            if (wr) chk("dq_wr", {16'b0, sram_dq}, {16'b0, hi ? wd[31:16] : wd[15:0]});
            else    chk("dq_rd", {16'b0, sram_dq}, {16'b0, hi ? old[31:16] : old[15:0]});
         end else begin
            chk("ready_done", {31'b0, ready}, 32'd1);
            chk("done_pins", {12'b0, sram_addr, we_n, oe_n}, {12'b0, 18'd0, 2'b11});
            chk("read_data", read_data, exp_rd);
         end
      end
      if (wr) begin
         ref_mem[w] = wd;
         chk("sram_img", {sram[{w, 1'b1}], sram[{w, 1'b0}]}, wd);
      end
      cur_rd = exp_rd;
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t        tbl [6];
   logic [17:0] aseq [$];
   logic [31:0] eff_r;
   bit [16:0]   w_r;
   int unsigned op;
   bit          r_rd, r_wr;
   logic [31:0] exp_r;

   initial begin
      // Store, load back, conflicting rd+wr, load, negative offset wrap,
      // and an alias 2^19 bytes up.
      tbl[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h0};
      tbl[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF};
      tbl[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF};
      tbl[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h12345678};
      tbl[4] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 32'h12345678};
      tbl[5] = '{1'b1, 1'b0, 32'd1020 + 32'd524288, 32'h0, 32'hCAFEF00D};

      // Reset with a load pending.
      rst_n = 1'b0; rd_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_read_data", read_data, 32'h0);
      chk("rst_pins", {12'b0, sram_addr, we_n, oe_n}, {12'b0, 18'd0, 2'b11});
      chk("rst_ready_req", {31'b0, ready}, 32'd0);
      rd_en = 1'b0; #1;
      chk("rst_ready_idle", {31'b0, ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", {31'b0, ready}, 32'd1);

      for (int i = 0; i < 6; i++)
         run_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
      chk("conflict_lo", {16'b0, sram[0]}, 32'h5678);
      chk("conflict_hi", {16'b0, sram[1]}, 32'h1234);
      chk("wrap_word", ref_rd(17'h1FFFF), 32'hCAFEF00D);

      // Back-to-back loads with rd_en held high.
      poke(17'd0, 32'h11112222);
      poke(17'd1, 32'h33334444);
      @(posedge clk); #1;
      rd_en = 1'b1; address = 32'd1024;
      for (int c = 0; c < 2 * P; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            if (c == 1) address = 32'd1028;
         end
         @(negedge clk);
         chk("b2b_ready", {31'b0, ready}, {31'b0, (c % P) == P - 1});
         if (!oe_n) aseq.push_back(sram_addr);
         if (c == P - 1)     chk("b2b_rd0", read_data, 32'h11112222);
         if (c == 2 * P - 1) chk("b2b_rd1", read_data, 32'h33334444);
      end
      @(posedge clk); #1;
      rd_en = 1'b0;
      cur_rd = 32'h33334444;
      chk("b2b_len", aseq.size(), 4 * AC);
      for (int i = 0; i < aseq.size() && i < 4 * AC; i++)
         chk("b2b_addr", {14'b0, aseq[i]}, i / AC);

      // Abort a store at the start of its high half.
      poke(17'd3, 32'h77771111);
      @(negedge clk);
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1036; write_data = 32'hA1B2C3D4;
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      chk("abort_pins", {12'b0, sram_addr, we_n, oe_n}, {12'b0, 18'd0, 2'b11});
      chk("abort_ready", {31'b0, ready}, 32'd1);
      chk("abort_read_data", read_data, 32'h0);
      chk("abort_lo_written", {16'b0, sram[6]}, 32'hC3D4);
      chk("abort_hi_kept", {16'b0, sram[7]}, 32'h7777);
      ref_mem[17'd3] = 32'h7777C3D4;
      cur_rd = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      poke(17'd4, 32'h0BADCAFE);
      run_req(1'b1, 1'b0, 32'd1040, 32'h0, 32'h0BADCAFE);

      // Random mix of loads, stores and conflicts over a small window.
      for (int i = 0; i < 40; i++) begin
         op    = $urandom_range(0, 2);
         r_rd  = (op != 1);
         r_wr  = (op != 0);
         w_r   = 17'($urandom_range(0, 15));
         eff_r = {13'($urandom), w_r, 2'($urandom)};
         exp_r = (r_rd && !r_wr) ? ref_rd(w_r) : cur_rd;
         run_req(r_rd, r_wr, eff_r + BASE, $urandom, exp_r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
# sram_controller

Responder for the MEM stage data-memory interface: accepts one 32-bit load or store per request and performs it as two 16-bit accesses on an external asynchronous SRAM. It drives `ready` low while an access is in progress, so the MEM stage can hold `hazard`/freeze on the pipeline until `ready` returns high. It sits between `MEM_Stage_Module` and the board SRAM pins. It replaces the internal data-memory array in the MEM stage.

## Interface
Parameters:
- `BASE_ADDR`, 1024: CPU data address that maps to SRAM word 0.
- `ACCESS_CYCLES`, 2: cycles spent on each 16-bit half. Legal range is ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rd_en`  in  1  load request from MEM stage.
- `wr_en`  in  1  store request from MEM stage.
- `address`  in  32  CPU byte address (ALU result).
- `write_data`  in  32  store data (Val_Rm).
- `read_data`  out  32  registered load result.
- `ready`  out  1  high when no access is pending or the access just completed; MEM stage freezes the pipeline while it is low.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM halfword address.
- `SRAM_WE_N`  out  1  SRAM write enable, active-low.
- `SRAM_OE_N`  out  1  SRAM output enable, active-low.

## Operation
- Effective address `eff = address - BASE_ADDR`, computed modulo 2^32.
  - Low half address: `{eff[18:2], 1'b0}`. High half address: `{eff[18:2], 1'b1}`.
  - `eff[1:0]` and `eff[31:19]` are ignored. Out-of-range addresses wrap silently.
- Request `req = rd_en | wr_en`. If both are high, the request is a write and `read_data` is not updated.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if `req`, latch `eff[18:2]`, `write_data` and op type (write/read), clear the cycle counter, then go to LO. Otherwise stay in IDLE.
  - LO: access the low half for `ACCESS_CYCLES` cycles, then go to HI.
  - HI: access the high half for `ACCESS_CYCLES` cycles, then go to DONE.
  - DONE: one cycle, then go to IDLE unconditionally.
- `ready` is combinational: `ready = (state==IDLE && !req) || state==DONE`.
- Pin behaviour in LO/HI:
  - `SRAM_ADDR` = the current half's address.
  - Write: `SRAM_WE_N=0`, `SRAM_OE_N=1`, `SRAM_DQ` driven with the current half (`wdata[15:0]` in LO, `wdata[31:16]` in HI).
  - Read: `SRAM_WE_N=1`, `SRAM_OE_N=0`, `SRAM_DQ` = Z.
  - `SRAM_DQ` is never driven during reads.
- Pin behaviour in IDLE/DONE: `SRAM_ADDR=0`, `SRAM_WE_N=1`, `SRAM_OE_N=1`, `SRAM_DQ`=Z.
- Read capture:
  - `SRAM_DQ` is sampled into a halfword register on the last LO cycle.
  - On the last HI cycle, `read_data <= {SRAM_DQ, lo_half}`.
  - `read_data` holds its value until the next read completes.
- Request inputs are only examined in IDLE. Deasserting `req` or changing `address` mid-access has no effect; the latched access completes.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE and counter=0.
  - Output values under reset: `read_data`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z.
  - `ready` = `!req` while in reset.
- Reset asserted mid-access aborts immediately. Partial writes are not rolled back, and `read_data` is cleared.
- Request first seen in IDLE at edge cycle t: `ready`=0 from t (same cycle, combinational).
  - LO covers t+1 .. t+ACCESS_CYCLES.
  - HI covers the next `ACCESS_CYCLES` cycles.
  - DONE (`ready`=1) is at cycle t+1+2·ACCESS_CYCLES. With the default this is t+5.
- Total occupancy per request is 2+2·ACCESS_CYCLES cycles, including DONE.
- Back-to-back requests: the pipeline advances on the DONE edge. A request present in the following IDLE cycle drops `ready` in that same cycle and starts a new access.
- `read_data` is valid in the DONE cycle and is sampled by the MEM pipeline register on that edge.

## Test plan
- Reset: hold `rst`=0 with `rd_en`=1 → `read_data`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z, `ready`=0. Release with no request → `ready`=1.
- Store: `wr_en`=1, `address`=1032, `write_data`=0xDEADBEEF at t.
  - LO at t+1..t+2: `SRAM_ADDR`=4, DQ=0xBEEF, `WE_N`=0.
  - HI at t+3..t+4: `SRAM_ADDR`=5, DQ=0xDEAD.
  - t+5: `ready`=1.
- Load from the same address against a behavioural SRAM model → `OE_N`=0 for 4 cycles, DQ never driven by the DUT, `read_data`=0xDEADBEEF at t+5.
- Back-to-back: `rd_en` held high across two loads (addresses 1024, 1028) → `ready` high for exactly one cycle between accesses, second result correct, `SRAM_ADDR` sequence 0,0,1,1 then 2,2,3,3.
- Conflict: `rd_en`=`wr_en`=1, `address`=1024, `write_data`=0x12345678 → write performed (SRAM words 0/1 = 0x5678/0x1234), `read_data` unchanged.
- Abort: assert `rst`=0 at t+3 of a store → `WE_N`=1 and DQ=Z immediately, state IDLE. After release, a new load from 1040 completes in 5 cycles with correct data.
